// File: rtl/compare_cross_tracker_if.sv
// Sample/result bundle for compare_cross_tracker.
//   master: drives en, clear, in_valid, a, b; observes the compare flags,
//           crossing pulses, crossing count and interval measurement.
//   slave : the tracker side (mirror of master).
interface compare_cross_tracker_if #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 16
);
  logic             en;
  logic             clear;
  logic             in_valid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             eq;
  logic             lt;
  logic             gt;
  logic             cross_up;
  logic             cross_dn;
  logic [CNT_W-1:0] cross_count;
  logic [CNT_W-1:0] interval;
  logic             interval_valid;

  modport master (
    output en, clear, in_valid, a, b,
    input  eq, lt, gt, cross_up, cross_dn, cross_count, interval, interval_valid
  );

  modport slave (
    input  en, clear, in_valid, a, b,
    output eq, lt, gt, cross_up, cross_dn, cross_count, interval, interval_valid
  );
endinterface

// File: rtl/compare_cross_tracker.sv
// compare_cross_tracker: registers the signed eq/lt/gt relation of two
// streamed samples, tracks the sign of a-b with hysteresis, pulses on
// upward/downward crossings, counts crossings and measures the number of
// accepted samples between consecutive crossings.
// Ports:
//   clk   - rising-edge clock
//   reset - asynchronous, active-low reset
//   bus   - slave modport: en, clear, in_valid, a, b in; eq, lt, gt,
//           cross_up, cross_dn, cross_count, interval, interval_valid out
module compare_cross_tracker #(
  parameter int WIDTH = 16,
  parameter int HYST  = 0,
  parameter int CNT_W = 16
) (
  input logic                    clk,
  input logic                    reset,
  compare_cross_tracker_if.slave bus
);

  typedef enum logic [1:0] {
    UNKNOWN = 2'd0,
    ABOVE   = 2'd1,
    BELOW   = 2'd2
  } state_t;

  localparam logic signed [WIDTH:0] HYST_P = (WIDTH+1)'(HYST);
  localparam logic signed [WIDTH:0] HYST_N = -HYST_P;
  localparam logic [CNT_W-1:0]      ONE    = CNT_W'(1);

  state_t           state, state_next;
  logic             eq_r, lt_r, gt_r;
  logic             up_r, dn_r;
  logic [CNT_W-1:0] count_r, interval_r, scnt;
  logic             seen, ivalid_r;

  logic signed [WIDTH:0] d;
  logic                  accept;
  logic                  up_n, dn_n;
  logic [CNT_W-1:0]      scnt_inc;

  // One extra bit keeps a-b exact over the full signed range.
  assign d        = $signed({bus.a[WIDTH-1], bus.a}) - $signed({bus.b[WIDTH-1], bus.b});
  assign accept   = bus.en && bus.in_valid && !bus.clear;
  assign scnt_inc = (scnt == '1) ? scnt : scnt + ONE;

  always_comb begin
    state_next = state;
    up_n       = 1'b0;
    dn_n       = 1'b0;
    case (state)
      UNKNOWN: begin
        if (d > HYST_P)      state_next = ABOVE;
        else if (d < HYST_N) state_next = BELOW;
      end
      ABOVE: begin
        if (d < HYST_N) begin
          state_next = BELOW;
          dn_n       = 1'b1;
        end
      end
      BELOW: begin
        if (d > HYST_P) begin
          state_next = ABOVE;
          up_n       = 1'b1;
        end
      end
      default: state_next = UNKNOWN;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= UNKNOWN;
      eq_r       <= 1'b0;
      lt_r       <= 1'b0;
      gt_r       <= 1'b0;
      up_r       <= 1'b0;
      dn_r       <= 1'b0;
      count_r    <= '0;
      interval_r <= '0;
      scnt       <= '0;
      seen       <= 1'b0;
      ivalid_r   <= 1'b0;
    end else if (!bus.en) begin
      // Pulses are single-cycle even while everything else is frozen.
      up_r <= 1'b0;
      dn_r <= 1'b0;
    end else if (bus.clear) begin
      state      <= UNKNOWN;
      eq_r       <= 1'b0;
      lt_r       <= 1'b0;
      gt_r       <= 1'b0;
      up_r       <= 1'b0;
      dn_r       <= 1'b0;
      count_r    <= '0;
      interval_r <= '0;
      scnt       <= '0;
      seen       <= 1'b0;
      ivalid_r   <= 1'b0;
    end else begin
      up_r <= accept && up_n;
      dn_r <= accept && dn_n;
      if (accept) begin
        state <= state_next;
        eq_r  <= (d == '0);
        lt_r  <= d[WIDTH];
        gt_r  <= !d[WIDTH] && (d != '0);
        if (up_n || dn_n) begin
          count_r    <= count_r + ONE;
          interval_r <= scnt_inc;
          scnt       <= '0;
          seen       <= 1'b1;
          if (seen) ivalid_r <= 1'b1;
        end else begin
          scnt <= scnt_inc;
        end
      end
    end
  end

  assign bus.eq             = eq_r;
  assign bus.lt             = lt_r;
  assign bus.gt             = gt_r;
  assign bus.cross_up       = up_r;
  assign bus.cross_dn       = dn_r;
  assign bus.cross_count    = count_r;
  assign bus.interval       = interval_r;
  assign bus.interval_valid = ivalid_r;

endmodule

// File: tb/tb_compare_cross_tracker.sv
// Self-checking bench for compare_cross_tracker. Two instances share the
// same stimulus: inst0 (HYST=4, CNT_W=16) and inst1 (HYST=0, CNT_W=4).
// The driver pushes the reference model's expected outputs into a queue per
// instance; a separate monitor pops and compares one entry per clock.
module tb_compare_cross_tracker;

  typedef struct {
    int eq, lt, gt, up, dn, cnt, intv, iv;
  } exp_t;

  logic clk;
  logic reset;

  compare_cross_tracker_if #(.WIDTH(16), .CNT_W(16)) bus0 ();
  compare_cross_tracker_if #(.WIDTH(16), .CNT_W(4))  bus1 ();

  compare_cross_tracker #(.WIDTH(16), .HYST(4), .CNT_W(16)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0.slave)
  );
  compare_cross_tracker #(.WIDTH(16), .HYST(0), .CNT_W(4)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_fail   = 0;

  exp_t q0[$];
  exp_t q1[$];

  // Reference model: sign state as -1 (below), 0 (unknown), +1 (above).
  int   hyst[2]  = '{4, 0};
  int   cmax[2]  = '{65535, 15};
  int   m_sign[2];
  int   m_scnt[2];
  int   m_seen[2];
  exp_t m_out[2];

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset(input int i);
    m_sign[i] = 0;
    m_scnt[i] = 0;
    m_seen[i] = 0;
    m_out[i]  = '{0, 0, 0, 0, 0, 0, 0, 0};
  endtask

  task automatic model_step(input int i, input bit r, input bit e, input bit c,
                            input bit v, input int av, input int bv);
    int  d;
    bit  crossed;
    if (!r || (e && c)) begin
      model_reset(i);
      return;
    end
    m_out[i].up = 0;
    m_out[i].dn = 0;
    if (!e || !v) return;
    d = av - bv;
    m_out[i].eq = (d == 0) ? 1 : 0;
    m_out[i].lt = (d < 0) ? 1 : 0;
    m_out[i].gt = (d > 0) ? 1 : 0;
    crossed = 0;
    if (m_sign[i] == 0) begin
      if (d > hyst[i]) m_sign[i] = 1;
      else if (d < -hyst[i]) m_sign[i] = -1;
    end else if (m_sign[i] == 1 && d < -hyst[i]) begin
      m_sign[i] = -1; m_out[i].dn = 1; crossed = 1;
    end else if (m_sign[i] == -1 && d > hyst[i]) begin
      m_sign[i] = 1;  m_out[i].up = 1; crossed = 1;
    end
    if (crossed) begin
      m_out[i].cnt  = (m_out[i].cnt + 1) % (cmax[i] + 1);
      m_out[i].intv = (m_scnt[i] + 1 > cmax[i]) ? cmax[i] : m_scnt[i] + 1;
      m_scnt[i]     = 0;
      if (m_seen[i] != 0) m_out[i].iv = 1;
      m_seen[i] = 1;
    end else begin
      m_scnt[i] = (m_scnt[i] + 1 > cmax[i]) ? cmax[i] : m_scnt[i] + 1;
    end
  endtask

  // One call per clock: inputs are set 2 time units after a rising edge and
  // the model's outputs for the following edge are queued.
  task automatic drive(input bit r, input bit e, input bit c, input bit v,
                       input int ai, input int bi);
    logic [15:0] a16, b16;
    @(posedge clk);
    #2;
    a16 = 16'(ai);
    b16 = 16'(bi);
    if (!r && reset) begin
      reset = 1'b0;
      #1;
      check("async_rst_inst0",
            {bus0.eq, bus0.lt, bus0.gt, bus0.cross_up, bus0.cross_dn,
             bus0.cross_count, bus0.interval, bus0.interval_valid}, 0);
      check("async_rst_inst1",
            {bus1.eq, bus1.lt, bus1.gt, bus1.cross_up, bus1.cross_dn,
             bus1.cross_count, bus1.interval, bus1.interval_valid}, 0);
    end
    reset = r;
    bus0.en = e; bus0.clear = c; bus0.in_valid = v; bus0.a = a16; bus0.b = b16;
    bus1.en = e; bus1.clear = c; bus1.in_valid = v; bus1.a = a16; bus1.b = b16;
    for (int i = 0; i < 2; i++)
      model_step(i, r, e, c, v, int'($signed(a16)), int'($signed(b16)));
    q0.push_back(m_out[0]);
    q1.push_back(m_out[1]);
  endtask

  task automatic compare_all(input string tag, input exp_t act, input exp_t exp);
    check({tag, ".eq"},             act.eq,   exp.eq);
    check({tag, ".lt"},             act.lt,   exp.lt);
    check({tag, ".gt"},             act.gt,   exp.gt);
    check({tag, ".cross_up"},       act.up,   exp.up);
    check({tag, ".cross_dn"},       act.dn,   exp.dn);
    check({tag, ".cross_count"},    act.cnt,  exp.cnt);
    check({tag, ".interval"},       act.intv, exp.intv);
    check({tag, ".interval_valid"}, act.iv,   exp.iv);
  endtask

  // Monitor: every cycle the DUT presents a fresh output set.
  initial begin
    exp_t e, act;
    forever begin
      @(posedge clk);
      #1;
      if (q0.size() > 0) begin
        e   = q0.pop_front();
        act = '{int'(bus0.eq), int'(bus0.lt), int'(bus0.gt), int'(bus0.cross_up),
                int'(bus0.cross_dn), int'(bus0.cross_count), int'(bus0.interval),
                int'(bus0.interval_valid)};
        compare_all("inst0", act, e);
      end
      if (q1.size() > 0) begin
        e   = q1.pop_front();
        act = '{int'(bus1.eq), int'(bus1.lt), int'(bus1.gt), int'(bus1.cross_up),
                int'(bus1.cross_dn), int'(bus1.cross_count), int'(bus1.interval),
                int'(bus1.interval_valid)};
        compare_all("inst1", act, e);
      end
    end
  end

  initial begin
    int hseq[7] = '{10, 3, -3, -4, -5, 4, 5};
    int av, bv;
    bit e, c, v;

    reset = 1'b0;
    bus0.en = 0; bus0.clear = 0; bus0.in_valid = 0; bus0.a = '0; bus0.b = '0;
    bus1.en = 0; bus1.clear = 0; bus1.in_valid = 0; bus1.a = '0; bus1.b = '0;
    for (int i = 0; i < 2; i++) model_reset(i);

    // Reset held, then released with en=1 and no valid input.
    for (int i = 0; i < 3; i++)  drive(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) drive(1, 1, 0, 0, 0, 0);

    // Compare flags at the signed extremes and equality.
    drive(1, 1, 0, 1, -32768, 32767);
    drive(1, 1, 0, 1, 32767, -32768);
    drive(1, 1, 0, 1, 'h1234, 'h1234);
    drive(1, 1, 0, 0, 0, 0);

    // Hysteresis sequence from a cleared start.
    drive(1, 1, 1, 0, 0, 0);
    foreach (hseq[k]) drive(1, 1, 0, 1, hseq[k], 0);
    drive(1, 1, 0, 0, 0, 0);
    check("hyst_cross_count", bus0.cross_count, 2);
    check("hyst_interval_valid", bus0.interval_valid, 1);

    // Interval measurement and saturation on the 4-bit instance.
    drive(1, 1, 1, 0, 0, 0);
    for (int k = 0; k < 6; k++)  drive(1, 1, 0, 1, 5, 0);
    for (int k = 0; k < 6; k++)  drive(1, 1, 0, 1, -5, 0);
    drive(1, 1, 0, 1, 5, 0);
    drive(1, 1, 0, 0, 0, 0);
    check("interval_six", bus1.interval, 6);
    for (int k = 0; k < 25; k++) drive(1, 1, 0, 1, 5, 0);
    drive(1, 1, 0, 1, -5, 0);
    drive(1, 1, 0, 0, 0, 0);
    check("interval_saturated", bus1.interval, 15);

    // 17 back-to-back crossings wrap the 4-bit counter to 1.
    drive(1, 1, 1, 0, 0, 0);
    drive(1, 1, 0, 1, 1, 0);
    for (int k = 0; k < 17; k++) drive(1, 1, 0, 1, (k % 2 == 0) ? -1 : 1, 0);
    drive(1, 1, 0, 0, 0, 0);
    check("count_wrap", bus1.cross_count, 1);
    check("back_to_back_interval", bus1.interval, 1);

    // Enable low freezes state despite valid crossing samples.
    drive(1, 1, 0, 1, 50, 0);
    for (int k = 0; k < 4; k++) drive(1, 0, 0, 1, (k % 2 == 0) ? -50 : 50, 0);
    drive(1, 1, 0, 0, 0, 0);

    // Clear together with a crossing sample.
    drive(1, 1, 0, 1, -50, 0);
    drive(1, 1, 1, 1, 50, 0);
    drive(1, 1, 0, 0, 0, 0);

    // Randomized traffic.
    for (int k = 0; k < 1500; k++) begin
      e = ($urandom % 10) != 0;
      c = ($urandom % 60) == 0;
      v = ($urandom % 10) < 7;
      if ($urandom % 8 == 0) begin
        av = int'($signed(16'($urandom)));
        bv = int'($signed(16'($urandom)));
      end else begin
        av = int'($urandom_range(0, 40)) - 20;
        bv = int'($urandom_range(0, 16)) - 8;
      end
      drive(1, e, c, v, av, bv);
    end

    // Async reset after three crossings, then recovery.
    drive(1, 1, 1, 0, 0, 0);
    drive(1, 1, 0, 1, 50, 0);
    drive(1, 1, 0, 1, -50, 0);
    drive(1, 1, 0, 1, 50, 0);
    drive(1, 1, 0, 1, -50, 0);
    drive(0, 1, 0, 1, 50, 0);
    drive(0, 1, 0, 0, 0, 0);
    drive(1, 1, 0, 1, 50, 0);
    drive(1, 1, 0, 1, -50, 0);
    drive(1, 1, 0, 0, 0, 0);
    check("post_reset_first_cross_iv", bus0.interval_valid, 0);
    drive(1, 1, 0, 1, 50, 0);
    drive(1, 1, 0, 0, 0, 0);
    drive(1, 1, 0, 0, 0, 0);

    @(posedge clk);
    #3;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
